// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with direct-mapped BTB; redirects override prediction.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_gen #(
    parameter int          BTB_WIDTH = 6,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    input  logic        pc_ready,
    input  logic        pred_taken,
    output logic [31:0] pred_next_pc,
    output logic        pred_btb_hit,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_br,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_btb_hits
);

    localparam int ENTRIES = 1 << BTB_WIDTH;
    localparam int TAG_W   = 30 - BTB_WIDTH;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_pc;
    logic [31:0]         w_pc_nxt;

    logic [ENTRIES-1:0]  r_btb_vld;
    logic [TAG_W-1:0]    r_btb_tag [ENTRIES];
    logic [29:0]         r_btb_tgt [ENTRIES];

    logic [BTB_WIDTH-1:0] w_lk_idx;
    logic [TAG_W-1:0]     w_lk_tag;
    logic [BTB_WIDTH-1:0] w_upd_idx;
    logic [TAG_W-1:0]     w_upd_tag;
    logic                 w_hit;
    logic                 w_fire;
    logic                 w_take_btb;
    logic [31:0]          w_pc_plus4;
    logic                 w_unused;

    assign w_unused = ^{redirect_pc[1:0], upd_target[1:0]};

    // Lookup reads the array before any same-edge update lands.
    assign w_lk_idx     = r_pc[BTB_WIDTH+1:2];
    assign w_lk_tag     = r_pc[31:BTB_WIDTH+2];
    assign w_upd_idx    = upd_pc[BTB_WIDTH+1:2];
    assign w_upd_tag    = upd_pc[31:BTB_WIDTH+2];
    assign w_hit        = r_btb_vld[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_take_btb   = w_hit && pred_taken;
    assign w_pc_plus4   = r_pc + 32'd4;

    assign pc_out       = r_pc;
    assign pc_valid     = (r_state == ST_RUN);
    assign w_fire       = pc_valid && pc_ready;
    assign pred_btb_hit = w_hit;
    assign pred_next_pc = w_take_btb ? {r_btb_tgt[w_lk_idx], 2'b00} : w_pc_plus4;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_INIT:   w_state_nxt = ST_RUN;
            ST_RUN:    if (redirect_valid) w_state_nxt = ST_BUBBLE;
            ST_BUBBLE: if (!redirect_valid) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_INIT;
        endcase
        if (redirect_valid) begin
            w_pc_nxt = {redirect_pc[31:2], 2'b00};
        end else if (w_fire) begin
            w_pc_nxt = pred_next_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Not-taken branches leave the entry alone; a non-branch aliasing the tag evicts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btb_vld <= '0;
        end else if (upd_valid) begin
            if (upd_is_br && upd_taken) begin
                r_btb_vld[w_upd_idx] <= 1'b1;
            end else if (!upd_is_br && (r_btb_tag[w_upd_idx] == w_upd_tag)) begin
                r_btb_vld[w_upd_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid && upd_is_br && upd_taken) begin
            r_btb_tag[w_upd_idx] <= w_upd_tag;
            r_btb_tgt[w_upd_idx] <= upd_target[31:2];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_redirects;
    logic [31:0] r_perf_btb_hits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_redirects <= 32'h0;
            r_perf_btb_hits  <= 32'h0;
        end else begin
            if (redirect_valid) r_perf_redirects <= r_perf_redirects + 32'd1;
            if (w_fire && w_take_btb) r_perf_btb_hits <= r_perf_btb_hits + 32'd1;
        end
    end

    assign perf_redirects = r_perf_redirects;
    assign perf_btb_hits  = r_perf_btb_hits;
`else
    assign perf_redirects = 32'h0;
    assign perf_btb_hits  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed vector table followed by randomized run against a reference model.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        pc_ready = 1'b0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_next_pc;
    logic        pred_btb_hit;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_is_br = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic [31:0] perf_redirects;
    logic [31:0] perf_btb_hits;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(.BTB_WIDTH(6), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset),
        .pc_out(pc_out), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .pred_taken(pred_taken), .pred_next_pc(pred_next_pc), .pred_btb_hit(pred_btb_hit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .perf_redirects(perf_redirects), .perf_btb_hits(perf_btb_hits)
    );

    // Reference model: PC, "issuing" flag, first-cycle flag, BTB as plain arrays.
    bit [31:0]   m_pc;
    bit          m_valid;
    bit          m_first;
    bit          m_vld [64];
    int unsigned m_tag [64];
    bit [31:0]   m_tgt [64];
    int unsigned m_redir;
    int unsigned m_hits;

    typedef struct {
        bit        rv;
        bit [31:0] rpc;
        bit        rdy, pt, uv;
        bit [31:0] upc;
        bit        ubr, utk;
        bit [31:0] utgt;
        bit [31:0] e_pc;
        bit        e_vld, e_hit;
        bit [31:0] e_next;
    } vec_t;

    vec_t vt [40];
    int   nv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h100; m_valid = 1'b0; m_first = 1'b1;
        m_redir = 0; m_hits = 0;
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
    endtask

    function automatic bit m_hit(input bit [31:0] pc);
        int unsigned idx;
        idx = (pc / 4) % 64;
        return m_vld[idx] && (m_tag[idx] == pc / 256);
    endfunction

    function automatic bit [31:0] m_pred(input bit [31:0] pc, input bit pt);
        if (m_hit(pc) && pt) return m_tgt[(pc / 4) % 64];
        return pc + 32'd4;
    endfunction

    task automatic drive(input bit rv, input bit [31:0] rpc, input bit rdy, input bit pt,
                         input bit uv, input bit [31:0] upc, input bit ubr, input bit utk,
                         input bit [31:0] utgt);
        redirect_valid = rv; redirect_pc = rpc; pc_ready = rdy; pred_taken = pt;
        upd_valid = uv; upd_pc = upc; upd_is_br = ubr; upd_taken = utk; upd_target = utgt;
        #1;
        chk("model_pc_out", pc_out, m_pc);
        chk("model_pc_valid", {31'h0, pc_valid}, {31'h0, m_valid});
        if (m_valid) begin
            chk("model_btb_hit", {31'h0, pred_btb_hit}, {31'h0, m_hit(m_pc)});
            chk("model_next_pc", pred_next_pc, m_pred(m_pc, pt));
        end
    endtask

    task automatic tick();
        bit          fire;
        bit          taken_hit;
        bit [31:0]   pn;
        int unsigned idx;
        fire      = m_valid && pc_ready;
        taken_hit = m_hit(m_pc) && pred_taken;
        pn        = m_pred(m_pc, pred_taken);
        @(posedge clk);
        if (redirect_valid) m_redir++;
        if (fire && taken_hit) m_hits++;
        if (redirect_valid) m_pc = redirect_pc & ~32'h3;
        else if (fire) m_pc = pn;
        m_valid = m_first ? 1'b1 : !redirect_valid;
        m_first = 1'b0;
        if (upd_valid) begin
            idx = (upd_pc / 4) % 64;
            if (upd_is_br && upd_taken) begin
                m_vld[idx] = 1'b1;
                m_tag[idx] = upd_pc / 256;
                m_tgt[idx] = upd_target & ~32'h3;
            end else if (!upd_is_br && m_tag[idx] == upd_pc / 256) begin
                m_vld[idx] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_perf(input string tag);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_perf_redirects"}, perf_redirects, m_redir);
        chk({tag, "_perf_btb_hits"}, perf_btb_hits, m_hits);
`else
        chk({tag, "_perf_redirects"}, perf_redirects, 32'h0);
        chk({tag, "_perf_btb_hits"}, perf_btb_hits, 32'h0);
`endif
    endtask

    task automatic add(input bit rv, input bit [31:0] rpc, input bit rdy, input bit pt,
                       input bit uv, input bit [31:0] upc, input bit ubr, input bit utk,
                       input bit [31:0] utgt, input bit [31:0] e_pc, input bit e_vld,
                       input bit e_hit, input bit [31:0] e_next);
        vt[nv] = '{rv, rpc, rdy, pt, uv, upc, ubr, utk, utgt, e_pc, e_vld, e_hit, e_next};
        nv++;
    endtask

    initial begin
        // rv rpc          rdy pt uv upc     br tk tgt          exp_pc       vld hit next
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h100,      0, 0, 0);
        add(0, 0,            1, 0, 1, 32'h110,1, 1, 32'h200,    32'h100,      1, 0, 32'h104);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h104,      1, 0, 32'h108);
        add(0, 0,            0, 0, 0, 0,      0, 0, 0,          32'h108,      1, 0, 32'h10C);
        add(0, 0,            0, 0, 0, 0,      0, 0, 0,          32'h108,      1, 0, 32'h10C);
        add(0, 0,            0, 0, 0, 0,      0, 0, 0,          32'h108,      1, 0, 32'h10C);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h108,      1, 0, 32'h10C);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h10C,      1, 0, 32'h110);
        add(0, 0,            1, 1, 0, 0,      0, 0, 0,          32'h110,      1, 1, 32'h200);
        add(1, 32'h112,      1, 0, 0, 0,      0, 0, 0,          32'h200,      1, 0, 32'h204);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h110,      0, 0, 0);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h110,      1, 1, 32'h114);
        add(1, 32'h303,      1, 0, 0, 0,      0, 0, 0,          32'h114,      1, 0, 32'h118);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h300,      0, 0, 0);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h300,      1, 0, 32'h304);
        add(1, 32'h110,      1, 0, 1, 32'h110,0, 0, 0,          32'h304,      1, 0, 32'h308);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h110,      0, 0, 0);
        add(0, 0,            1, 1, 1, 32'h210,1, 1, 32'h400,    32'h110,      1, 0, 32'h114);
        add(1, 32'h110,      1, 0, 0, 0,      0, 0, 0,          32'h114,      1, 0, 32'h118);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h110,      0, 0, 0);
        add(1, 32'h210,      1, 1, 0, 0,      0, 0, 0,          32'h110,      1, 0, 32'h114);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h210,      0, 0, 0);
        add(0, 0,            1, 1, 0, 0,      0, 0, 0,          32'h210,      1, 1, 32'h400);
        add(1, 32'hFFFFFFFC, 1, 0, 0, 0,      0, 0, 0,          32'h400,      1, 0, 32'h404);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'hFFFFFFFC, 0, 0, 0);
        add(0, 0,            1, 1, 0, 0,      0, 0, 0,          32'hFFFFFFFC, 1, 0, 32'h0);
        add(0, 0,            0, 1, 1, 32'h0,  1, 1, 32'h800,    32'h0,        1, 0, 32'h4);
        add(0, 0,            1, 1, 0, 0,      0, 0, 0,          32'h0,        1, 1, 32'h800);
        add(1, 32'h500,      1, 0, 0, 0,      0, 0, 0,          32'h800,      1, 0, 32'h804);
        add(1, 32'h600,      1, 0, 0, 0,      0, 0, 0,          32'h500,      0, 0, 0);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h600,      0, 0, 0);
        add(0, 0,            1, 0, 0, 0,      0, 0, 0,          32'h600,      1, 0, 32'h604);

        m_reset();
        repeat (3) @(negedge clk);
        chk("reset_pc_out", pc_out, 32'h100);
        chk("reset_pc_valid", {31'h0, pc_valid}, 32'h0);
        chk_perf("reset");
        reset = 1'b0;

        for (int i = 0; i < nv; i++) begin
            drive(vt[i].rv, vt[i].rpc, vt[i].rdy, vt[i].pt, vt[i].uv, vt[i].upc,
                  vt[i].ubr, vt[i].utk, vt[i].utgt);
            chk($sformatf("vec%0d_pc_out", i), pc_out, vt[i].e_pc);
            chk($sformatf("vec%0d_pc_valid", i), {31'h0, pc_valid}, {31'h0, vt[i].e_vld});
            if (vt[i].e_vld) begin
                chk($sformatf("vec%0d_btb_hit", i), {31'h0, pred_btb_hit}, {31'h0, vt[i].e_hit});
                chk($sformatf("vec%0d_next_pc", i), pred_next_pc, vt[i].e_next);
            end
            tick();
        end
`ifdef FETCH_PERF_CNT_EN
        chk("dir_perf_redirects", perf_redirects, 32'd8);
        chk("dir_perf_btb_hits", perf_btb_hits, 32'd3);
`endif
        chk_perf("dir");

        // Asynchronous reset mid-cycle clears PC, FSM, BTB and counters at once.
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk("async_reset_pc_out", pc_out, 32'h100);
        chk("async_reset_pc_valid", {31'h0, pc_valid}, 32'h0);
        chk_perf("async_reset");
        @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) == 0,
                  ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1023) << 2,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3));
            tick();
        end
        chk_perf("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
